// File: rtl/fp_pkg.sv
// Shared definitions for the FPU datapath cores: FSM states, flag bit positions
// and format helpers that take the exponent/fraction widths as arguments.
package fp_pkg;

  typedef enum logic [2:0] {
    IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, PACK, DONE
  } state_t;

  localparam int FLG_INVALID   = 3;
  localparam int FLG_OVERFLOW  = 2;
  localparam int FLG_UNDERFLOW = 1;
  localparam int FLG_INEXACT   = 0;

  // Helpers work on a 64-bit container so any supported format fits.
  function automatic logic [63:0] field_mask(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic logic [63:0] exp_of(input logic [63:0] x, input int exp_w, input int man_w);
    return (x >> man_w) & field_mask(exp_w);
  endfunction

  function automatic logic [63:0] frac_of(input logic [63:0] x, input int man_w);
    return x & field_mask(man_w);
  endfunction

  function automatic logic [63:0] qnan_pat(input int exp_w, input int man_w);
    return (field_mask(exp_w) << man_w) | (64'd1 << (man_w - 1));
  endfunction

  function automatic logic [63:0] inf_pat(input logic sign, input int exp_w, input int man_w);
    return (64'(sign) << (exp_w + man_w)) | (field_mask(exp_w) << man_w);
  endfunction

  function automatic logic is_nan(input logic [63:0] x, input int exp_w, input int man_w);
    return (exp_of(x, exp_w, man_w) == field_mask(exp_w)) && (frac_of(x, man_w) != 64'd0);
  endfunction

  function automatic logic is_snan(input logic [63:0] x, input int exp_w, input int man_w);
    return is_nan(x, exp_w, man_w) && !x[man_w-1];
  endfunction

  function automatic logic is_inf(input logic [63:0] x, input int exp_w, input int man_w);
    return (exp_of(x, exp_w, man_w) == field_mask(exp_w)) && (frac_of(x, man_w) == 64'd0);
  endfunction

  function automatic logic is_zero(input logic [63:0] x, input int exp_w, input int man_w);
    return (exp_of(x, exp_w, man_w) == 64'd0) && (frac_of(x, man_w) == 64'd0);
  endfunction

  function automatic logic is_sub(input logic [63:0] x, input int exp_w, input int man_w);
    return (exp_of(x, exp_w, man_w) == 64'd0) && (frac_of(x, man_w) != 64'd0);
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input reports W.
module fp_lzc #(
  parameter  int W  = 27,
  localparam int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  x,
  output logic [CW-1:0] count
);

  // Ascending scan: the last hit is the most significant set bit.
  always_comb begin
    count = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (x[i]) count = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fp_addsub.sv
// Multi-cycle IEEE-754 adder/subtractor with strobe/ack handshakes, RNE rounding,
// full special-value handling and exception flags.
module fp_addsub
  import fp_pkg::*;
#(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_op,
  input  logic         in_stb,
  output logic         in_ack,
  output logic [W-1:0] out_z,
  output logic [3:0]   out_flags,
  output logic         out_stb,
  input  logic         out_ack
);

  localparam int XW    = MAN_W + 4;
  localparam int EW    = EXP_W + 2;
  localparam int CW    = $clog2(XW + 1);
  localparam int SHMAX = MAN_W + 3;
  localparam logic [W-1:0]  QNAN = W'(qnan_pat(EXP_W, MAN_W));
  localparam logic [W-1:0]  INF  = W'(inf_pat(1'b0, EXP_W, MAN_W));
  localparam logic [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);

  state_t state, next_state;

  logic [W-1:0]     opa, opb;
  logic             op_sub;
  logic             sa, sb;
  logic [EW-1:0]    ea, eb;
  logic [MAN_W:0]   ma, mb;
  logic             spec, spec_inv;
  logic [W-1:0]     spec_z;
  logic             sign_r, eff_sub;
  logic [EW-1:0]    exp_r;
  logic [XW-1:0]    xbig, xsmall;
  logic [XW:0]      sum;
  logic [XW-1:0]    norm_m;
  logic [MAN_W:0]   sig_r;
  logic             inexact_r;

  assign in_ack  = (state == IDLE);
  assign out_stb = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_stb) next_state = UNPACK;
      UNPACK:  next_state = ALIGN;
      ALIGN:   next_state = ADD;
      ADD:     next_state = NORM;
      NORM:    next_state = ROUND;
      ROUND:   next_state = PACK;
      PACK:    next_state = DONE;
      DONE:    if (out_ack) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  logic [EXP_W-1:0] a_exp, b_exp;
  logic b_sign_eff, a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
  assign a_exp      = opa[W-2:MAN_W];
  assign b_exp      = opb[W-2:MAN_W];
  assign b_sign_eff = opb[W-1] ^ op_sub;
  assign a_nan  = is_nan(64'(opa), EXP_W, MAN_W);
  assign b_nan  = is_nan(64'(opb), EXP_W, MAN_W);
  assign a_snan = is_snan(64'(opa), EXP_W, MAN_W);
  assign b_snan = is_snan(64'(opb), EXP_W, MAN_W);
  assign a_inf  = is_inf(64'(opa), EXP_W, MAN_W);
  assign b_inf  = is_inf(64'(opb), EXP_W, MAN_W);
  assign a_zero = is_zero(64'(opa), EXP_W, MAN_W);
  assign b_zero = is_zero(64'(opb), EXP_W, MAN_W);

  // Special results bypass the arithmetic path; priority NaN > inf > zero.
  logic spec_c, spec_inv_c;
  logic [W-1:0] spec_z_c;
  always_comb begin
    spec_c     = 1'b1;
    spec_inv_c = 1'b0;
    spec_z_c   = QNAN;
    if (a_nan || b_nan)                                spec_inv_c = a_snan || b_snan;
    else if (a_inf && b_inf && opa[W-1] != b_sign_eff) spec_inv_c = 1'b1;
    else if (a_inf)                                    spec_z_c = opa;
    else if (b_inf)                                    spec_z_c = {b_sign_eff, opb[W-2:0]};
    else if (a_zero && b_zero)                         spec_z_c = {opa[W-1] & b_sign_eff, {(W-1){1'b0}}};
    else if (a_zero)                                   spec_z_c = {b_sign_eff, opb[W-2:0]};
    else if (b_zero)                                   spec_z_c = opa;
    else                                               spec_c = 1'b0;
  end

  logic a_bigger;
  logic [EW-1:0] big_e, small_e, diff, shamt;
  logic [MAN_W:0] big_m, small_m;
  logic [2*XW-1:0] wide;
  logic [XW-1:0] xsmall_c;
  always_comb begin
    a_bigger = {ea, ma} >= {eb, mb};
    big_e    = a_bigger ? ea : eb;
    small_e  = a_bigger ? eb : ea;
    big_m    = a_bigger ? ma : mb;
    small_m  = a_bigger ? mb : ma;
    diff     = big_e - small_e;
    shamt    = (diff > EW'(SHMAX)) ? EW'(SHMAX) : diff;
    wide     = {small_m, 3'b000, {XW{1'b0}}} >> shamt;
    xsmall_c = {wide[2*XW-1:XW+1], wide[XW] | (|wide[XW-1:0])};
  end

  logic [CW-1:0] lz;
  logic [EW-1:0] lz_e, lim, nshift;
  logic [XW-1:0] norm_c;
  fp_lzc #(.W(XW)) u_lzc (.x(sum[XW-1:0]), .count(lz));

  // Left shift stops at the minimum exponent so small results stay subnormal.
  always_comb begin
    lz_e   = EW'(lz);
    lim    = exp_r - EW'(1);
    nshift = (lz_e > lim) ? lim : lz_e;
    norm_c = sum[XW-1:0] << nshift;
  end

  logic rnd_up;
  logic [MAN_W+1:0] rsum;
  assign rnd_up = norm_m[2] & (norm_m[3] | norm_m[1] | norm_m[0]);
  assign rsum   = {1'b0, norm_m[XW-1:3]} + {{(MAN_W+1){1'b0}}, rnd_up};

  logic [W-1:0] z_c;
  logic [3:0]   f_c;
  always_comb begin
    z_c = '0;
    f_c = '0;
    if (spec) begin
      z_c = spec_z;
      f_c[FLG_INVALID] = spec_inv;
    end else if (exp_r >= EMAX) begin
      z_c = {sign_r, INF[W-2:0]};
      f_c[FLG_OVERFLOW] = 1'b1;
      f_c[FLG_INEXACT]  = 1'b1;
    end else if (sig_r != '0) begin
      z_c = {sign_r, sig_r[MAN_W] ? exp_r[EXP_W-1:0] : {EXP_W{1'b0}}, sig_r[MAN_W-1:0]};
      f_c[FLG_UNDERFLOW] = !sig_r[MAN_W] && inexact_r;
      f_c[FLG_INEXACT]   = inexact_r;
    end
  end

  // One pipeline-free datapath: each state updates only the registers it owns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa <= '0; opb <= '0; op_sub <= 1'b0;
      sa <= 1'b0; sb <= 1'b0; ea <= '0; eb <= '0; ma <= '0; mb <= '0;
      spec <= 1'b0; spec_inv <= 1'b0; spec_z <= '0;
      sign_r <= 1'b0; eff_sub <= 1'b0; exp_r <= '0; xbig <= '0; xsmall <= '0;
      sum <= '0; norm_m <= '0; sig_r <= '0; inexact_r <= 1'b0;
      out_z <= '0; out_flags <= '0;
    end else begin
      case (state)
        IDLE: if (in_stb) begin
          opa <= in_a; opb <= in_b; op_sub <= in_op;
        end
        UNPACK: begin
          sa <= opa[W-1];
          sb <= b_sign_eff;
          ea <= (a_exp == '0) ? EW'(1) : EW'(a_exp);
          eb <= (b_exp == '0) ? EW'(1) : EW'(b_exp);
          ma <= {a_exp != '0, opa[MAN_W-1:0]};
          mb <= {b_exp != '0, opb[MAN_W-1:0]};
          spec <= spec_c; spec_inv <= spec_inv_c; spec_z <= spec_z_c;
        end
        ALIGN: begin
          sign_r  <= a_bigger ? sa : sb;
          eff_sub <= sa ^ sb;
          exp_r   <= big_e;
          xbig    <= {big_m, 3'b000};
          xsmall  <= xsmall_c;
        end
        ADD: sum <= eff_sub ? ({1'b0, xbig} - {1'b0, xsmall}) : ({1'b0, xbig} + {1'b0, xsmall});
        NORM: if (sum[XW]) begin
          norm_m <= {sum[XW:2], sum[1] | sum[0]};
          exp_r  <= exp_r + EW'(1);
        end else begin
          norm_m <= norm_c;
          exp_r  <= exp_r - nshift;
        end
        ROUND: begin
          if (rsum[MAN_W+1]) begin
            sig_r <= rsum[MAN_W+1:1];
            exp_r <= exp_r + EW'(1);
          end else begin
            sig_r <= rsum[MAN_W:0];
          end
          inexact_r <= |norm_m[2:0];
        end
        PACK: begin
          out_z <= z_c; out_flags <= f_c;
        end
        default: ;
      endcase
    end
  end

endmodule
